// File: rtl/pipe_pkg.sv
// Shared types, default widths and payload field offsets for the pipeline stage buffer.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 160;

    // Payload layout: data in the low bits, control directly above it.
    localparam int DATA_OFS = 0;

    function automatic int ctrl_ofs(input int data_w);
        return DATA_OFS + data_w;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single payload register with load enable, cleared by the asynchronous reset.
module pipe_entry_reg #(
    parameter int W = 168
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: non-blocking for state; the payload is reset because out_data must read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, optional 2-entry skid, flush and NOP masking.
// Define PIPE_STAGE_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`else
    output logic [1:0]        occupancy
`endif
);

    localparam int PAY_W    = CTRL_W + DATA_W;
    localparam int CTRL_OFS = ctrl_ofs(DATA_W);

    stage_state_e     state, state_nxt;
    logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
    logic             accept, take, main_load, skid_load;

    assign in_pay[CTRL_OFS +: CTRL_W] = in_ctrl;
    assign in_pay[DATA_OFS +: DATA_W] = in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_pay;

        case (state)
            EMPTY:   in_ready = 1'b1;
            BUSY:    in_ready = SKID ? 1'b1 : out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst)
            in_ready = 1'b0;

        accept = in_valid & in_ready;
        take   = out_valid & out_ready;

        case (state)
            EMPTY: if (accept) begin
                state_nxt = BUSY;
                main_load = 1'b1;
            end
            BUSY: begin
                if (accept && take) begin
                    main_load = 1'b1;
                end else if (take) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end
            end
            FULL: if (take) begin
                state_nxt = BUSY;
                main_load = 1'b1;
                main_d    = skid_q;
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush wins over accept and take; main keeps its data so out_data is not cleared.
        if (flush) begin
            state_nxt = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    pipe_entry_reg #(.W(PAY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(.W(PAY_W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (skid_load),
                .d    (in_pay),
                .q    (skid_q)
            );
        end else begin : g_no_skid
            logic skid_load_unused;
            assign skid_load_unused = skid_load;
            assign skid_q           = '0;
        end
    endgenerate

    assign out_valid = (state != EMPTY);
    assign out_ctrl  = out_valid ? main_q[CTRL_OFS +: CTRL_W] : '0;
    assign out_data  = main_q[DATA_OFS +: DATA_W];

    always_comb begin
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && occupancy != 2'd0 && flush_cnt != '1)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance and a SKID=0 instance on one clock.
module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [7:0]   in_ctrl;
    logic [159:0] in_data;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   out_ctrl;
    logic [159:0] out_data;
    logic [1:0]   occupancy;

    logic         in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]   out_ctrl0;
    logic [159:0] out_data0;
    logic [1:0]   occupancy0;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]  stall_cnt, stall_cnt0;
    logic [15:0]  flush_cnt, flush_cnt0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(160), .SKID(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_CNT_EN
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`else
        .occupancy (occupancy)
`endif
    );

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(160), .SKID(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_ctrl  (out_ctrl0),
        .out_data  (out_data0),
`ifdef PIPE_STAGE_PERF_CNT_EN
        .occupancy (occupancy0),
        .stall_cnt (stall_cnt0),
        .flush_cnt (flush_cnt0)
`else
        .occupancy (occupancy0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
        total++; if (out_data !== 160'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL reset_in_ready0 got=%b exp=0", in_ready0); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL release_occupancy got=%0d exp=0", occupancy); end
    endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
    task automatic test_perf_cnt();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 8'h51; in_data = 160'h51;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall_cnt got=%0d exp=5", stall_cnt); end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall_after_flush got=%0d exp=5", stall_cnt); end
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL perf_flush_cnt got=%0d exp=1", flush_cnt); end
        tick();
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL perf_flush_idle got=%0d exp=1", flush_cnt); end
    endtask
`endif

    task automatic test_pass_through();
        logic [7:0]   exp_ctrl;
        logic [159:0] exp_data;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_ctrl = (i == 0) ? 8'hA5 : 8'(8'hB0 + i);
            exp_data = 160'h1000 + 160'(i);
            in_valid = 1'b1; in_ctrl = exp_ctrl; in_data = exp_data;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready beat=%0d got=%b exp=1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_out_valid beat=%0d got=%b exp=1", i, out_valid); end
            total++; if (out_ctrl !== exp_ctrl) begin bad++; $display("FAIL pass_out_ctrl beat=%0d got=%h exp=%h", i, out_ctrl, exp_ctrl); end
            total++; if (out_data !== exp_data) begin bad++; $display("FAIL pass_out_data beat=%0d got=%h exp=%h", i, out_data, exp_data); end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL pass_occupancy beat=%0d got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_drain_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL pass_drain_ctrl got=%h exp=00", out_ctrl); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = 160'h1;
        tick();
        in_ctrl = 8'h12; in_data = 160'h2;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occupancy_full got=%0d exp=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
        total++; if (out_ctrl !== 8'h11) begin bad++; $display("FAIL bp_head_ctrl got=%h exp=11", out_ctrl); end
        in_ctrl = 8'h13; in_data = 160'h3;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_hold_occupancy got=%0d exp=2", occupancy); end
        total++; if (out_data !== 160'h1) begin bad++; $display("FAIL bp_hold_data got=%h exp=1", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 160'h2) begin bad++; $display("FAIL bp_second_data got=%h exp=2", out_data); end
        total++; if (out_ctrl !== 8'h12) begin bad++; $display("FAIL bp_second_ctrl got=%h exp=12", out_ctrl); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_second_occupancy got=%0d exp=1", occupancy); end
        tick();
        total++; if (out_data !== 160'h3) begin bad++; $display("FAIL bp_third_data got=%h exp=3", out_data); end
        total++; if (out_ctrl !== 8'h13) begin bad++; $display("FAIL bp_third_ctrl got=%h exp=13", out_ctrl); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h21; in_data = 160'h21;
        tick();
        in_ctrl = 8'h22; in_data = 160'h22;
        tick();
        flush = 1'b1; in_ctrl = 8'h23; in_data = 160'h23;
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_full_occupancy got=%0d exp=0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL flush_full_ctrl got=%h exp=00", out_ctrl); end
        total++; if (out_data !== 160'h21) begin bad++; $display("FAIL flush_full_data_kept got=%h exp=21", out_data); end
        flush = 1'b0; in_ctrl = 8'h31; in_data = 160'h31;
        tick();
        flush = 1'b1; in_ctrl = 8'h32; in_data = 160'h32;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready_ungated got=%b exp=1", in_ready); end
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_accept_occupancy got=%0d exp=0", occupancy); end
        total++; if (out_data !== 160'h31) begin bad++; $display("FAIL flush_accept_data got=%h exp=31", out_data); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
        in_valid = 1'b1; in_ctrl = 8'h33; in_data = 160'h33;
        tick();
        total++; if (out_data !== 160'h33) begin bad++; $display("FAIL flush_next_data got=%h exp=33", out_data); end
        total++; if (out_ctrl !== 8'h33) begin bad++; $display("FAIL flush_next_ctrl got=%h exp=33", out_ctrl); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_skid0();
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_ctrl = 8'h41; in_data = 160'h41;
        tick();
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL skid0_out_valid got=%b exp=1", out_valid0); end
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL skid0_in_ready_stalled got=%b exp=0", in_ready0); end
        in_ctrl = 8'h42; in_data = 160'h42;
        tick();
        total++; if (out_data0 !== 160'h41) begin bad++; $display("FAIL skid0_hold_data got=%h exp=41", out_data0); end
        total++; if (occupancy0 !== 2'd1) begin bad++; $display("FAIL skid0_occupancy got=%0d exp=1", occupancy0); end
        out_ready0 = 1'b1;
        #1;
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL skid0_in_ready_comb got=%b exp=1", in_ready0); end
        tick();
        total++; if (out_data0 !== 160'h42) begin bad++; $display("FAIL skid0_next_data got=%h exp=42", out_data0); end
        total++; if (out_ctrl0 !== 8'h42) begin bad++; $display("FAIL skid0_next_ctrl got=%h exp=42", out_ctrl0); end
        in_valid0 = 1'b0;
        tick();
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL skid0_drain_valid got=%b exp=0", out_valid0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h61; in_data = 160'h61;
        tick();
        in_ctrl = 8'h62; in_data = 160'h62;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rmid_pre_occupancy got=%0d exp=2", occupancy); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL rmid_out_ctrl got=%h exp=00", out_ctrl); end
        total++; if (out_data !== 160'h0) begin bad++; $display("FAIL rmid_out_data got=%h exp=0", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rmid_occupancy got=%0d exp=0", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_release_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_release_valid got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_ctrl = 8'h00; in_data = 160'h0;
        test_reset();
`ifdef PIPE_STAGE_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_skid0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register, successor of the fixed-field stage registers between ID/EXE/MEM/WB.
- Carries one opaque payload: a control field plus a data field.
- Adds valid/ready back-pressure with a 2-entry skid buffer, so a stalled consumer never drops a beat. Also adds synchronous flush and bubble (NOP) insertion.
- Instantiated once per stage boundary; the top level packs and unpacks the fields.

Parameters:
- CTRL_W, 8, control bits (WB_en, mem_r/w, branch, S, ...); forced to 0 on any bubble.
- DATA_W, 160, data bits (pc, operands, immediates, dest); hold value on bubble.
- SKID, 1, 1 = 2-entry skid buffer (full throughput); 0 = single entry, in_ready combinationally depends on out_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries and the current input beat.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  stage accepts the beat this cycle.
- in_ctrl  in  CTRL_W  control field.
- in_data  in  DATA_W  data field.
- out_valid  out  1  out_ctrl/out_data hold a live beat.
- out_ready  in  1  consumer takes the beat this cycle.
- out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data field of the main entry.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Reset: async on rst high. Behaviour while rst is high:
  - State EMPTY; main and skid registers cleared.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=0 while rst is high; in_ready=1 from the first edge after release.
- Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready. Both are evaluated at the same edge.
- Latency: an accepted beat appears on out_* the next cycle (1-cycle registered path); out_* are pure register outputs.
- FSM (SKID=1):
  - EMPTY: in_ready=1. accept -> BUSY, main<=in.
  - BUSY: in_ready=1.
    - accept&take -> BUSY, main<=in.
    - take only -> EMPTY.
    - accept only -> FULL, skid<=in.
  - FULL: in_ready=0.
    - take -> BUSY, main<=skid.
    - no take -> hold both entries.
- SKID=0:
  - in_ready = ~out_valid | out_ready.
  - States EMPTY/BUSY only; FULL unreachable; occupancy never exceeds 1.
- Flush: on an edge where flush=1, next state is EMPTY.
  - Both entries are dropped.
  - An accept in the same cycle is discarded.
  - out_valid=0 and out_ctrl=0 the following cycle.
  - out_data keeps its previous value; it is not cleared.
  - Flush has priority over accept and take.
  - in_ready is not gated by flush.
- Bubble: out_ctrl is a masked copy of main_ctrl (out_ctrl = out_valid ? main_ctrl : 0), so a stalled or empty stage presents NOP control.
- Ordering: beats leave in acceptance order; none is duplicated or lost except by flush.
- Reset mid-operation: immediate return to the reset state regardless of state; no partial update.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[15:0].
  - stall_cnt increments on every cycle with out_valid & ~out_ready.
  - flush_cnt increments on every edge with flush=1 while occupancy!=0.
  - Both counters saturate at all-ones and reset to 0 on rst.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package (pipe_pkg):
  - Stage FSM state enum: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - Default widths CTRL_W/DATA_W per stage boundary.
  - Field offsets used by the packing logic in the top level.
- One natural sub-module: pipe_entry_reg, a single clearable payload register with a load enable. Instantiated as main and skid (skid only when SKID=1).

Test Plan:
- Reset: assert rst mid-stream in FULL -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0 asynchronously; in_ready=1 on the first edge after release.
- Pass-through: out_ready=1, in_valid=1 with ctrl=8'hA5, data=32'h1000 (zero-extended) -> one cycle later out_valid=1, out_ctrl=A5, out_data=1000; one beat per cycle sustained over 16 beats.
- Back-pressure: out_ready=0, push beats 1,2 -> occupancy=2, in_ready=0, beat 3 held at producer. out_ready=1 -> outputs 1,2,3 in order, no loss.
- Flush while FULL with an accept in the same cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data unchanged; the flushed beat is never emitted.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.
- PIPE_STAGE_PERF_CNT_EN: 5 stalled cycles plus 1 flush at occupancy=1 -> stall_cnt=5, flush_cnt=1.
